// File: rtl/rs_mod_pkg.sv
// Shared definitions for the reliable-send flowstate modify path.
// Opcode codes and a constant-width helper.
package rs_mod_pkg;

  localparam logic [3:0] RS_OP_READ  = 4'b0000;
  localparam logic [3:0] RS_OP_WRITE = 4'b0001;
  localparam logic [3:0] RS_OP_CLEAR = 4'b1101;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/rs_id_fifo.sv
// In-order requester-ID FIFO with a combinational head.
// Push and pop may coincide, including when full.
module rs_id_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_id,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wr_q] = push_id;
      wr_d        = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign head  = mem_q[rd_q];
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));

endmodule

// File: rtl/flowstate_mod_arbiter.sv
// Flowstate RAM modify-port arbiter: round-robin grant into one command
// stage, in-order response routing back to requesters, CLEAR lock.
module flowstate_mod_arbiter
  import rs_mod_pkg::*;
#(
  parameter int NUM_REQ         = 2,
  parameter int ADDR_WIDTH      = 10,
  parameter int VALUE_WIDTH     = 32,
  parameter int OPCODE_WIDTH    = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter logic [OPCODE_WIDTH-1:0] CLEAR_OPCODE =
    OPCODE_WIDTH'(RS_OP_CLEAR)
) (
  input  logic clk,
  input  logic rst,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]      s_req_addr,
  input  logic [NUM_REQ*(VALUE_WIDTH+1)-1:0] s_req_data,
  input  logic [NUM_REQ*OPCODE_WIDTH-1:0]    s_req_opcode,
  input  logic [NUM_REQ-1:0]                 s_req_valid,
  output logic [NUM_REQ-1:0]                 s_req_ready,
  output logic [VALUE_WIDTH:0]               s_rsp_bdata,
  output logic [NUM_REQ-1:0]                 s_rsp_bvalid,
  input  logic [NUM_REQ-1:0]                 s_rsp_bready,
  output logic [ADDR_WIDTH-1:0]              m_mod_addr,
  output logic [VALUE_WIDTH:0]               m_mod_data,
  output logic [OPCODE_WIDTH-1:0]            m_mod_opcode,
  output logic                               m_mod_valid,
  input  logic                               m_mod_ready,
  input  logic [VALUE_WIDTH:0]               m_mod_bdata,
  input  logic                               m_mod_bvalid,
  output logic                               m_mod_bready,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                               clear_busy,
  output logic                               err_orphan_rsp
);

  localparam int ID_W = clog2(NUM_REQ);
  localparam int OW   = $clog2(MAX_OUTSTANDING + 1);
  localparam int DW   = VALUE_WIDTH + 1;

  logic [ID_W-1:0]         rr_q, rr_d;
  logic [ID_W-1:0]         gnt_idx, head_id;
  logic                    gnt_found;
  logic                    stage_free, can_accept, accept;
  logic                    is_clear, rsp_pop;
  logic                    fifo_empty, fifo_full;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DW-1:0]           sel_data;
  logic [OPCODE_WIDTH-1:0] sel_opcode;

  logic                    m_mod_valid_q, m_mod_valid_d;
  logic [ADDR_WIDTH-1:0]   m_mod_addr_q, m_mod_addr_d;
  logic [DW-1:0]           m_mod_data_q, m_mod_data_d;
  logic [OPCODE_WIDTH-1:0] m_mod_opcode_q, m_mod_opcode_d;
  logic [OW-1:0]           outstanding_q, outstanding_d;
  logic                    clear_busy_q, clear_busy_d;
  logic                    err_orphan_q, err_orphan_d;

  // Round-robin search starting at the pointer, wrapping past NUM_REQ-1.
  always_comb begin
    int idx;
    logic [ID_W-1:0] cand;
    idx       = 0;
    cand      = '0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = ID_W'(idx);
      if (!gnt_found && s_req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign sel_addr   = s_req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_data   = s_req_data[gnt_idx*DW +: DW];
  assign sel_opcode = s_req_opcode[gnt_idx*OPCODE_WIDTH +: OPCODE_WIDTH];

  assign stage_free = !m_mod_valid_q || m_mod_ready;
  assign can_accept = stage_free && !clear_busy_q && !fifo_full
                   && (outstanding_q < OW'(MAX_OUTSTANDING));
  assign accept     = can_accept && gnt_found;
  assign is_clear   = accept && (sel_opcode == CLEAR_OPCODE);

  always_comb begin
    s_req_ready = '0;
    if (accept) s_req_ready[gnt_idx] = 1'b1;
  end

  // Empty FIFO means nobody owns the beat: swallow it.
  always_comb begin
    s_rsp_bvalid = '0;
    if (m_mod_bvalid && !fifo_empty) s_rsp_bvalid[head_id] = 1'b1;
    m_mod_bready = fifo_empty || s_rsp_bready[head_id];
  end

  assign rsp_pop     = m_mod_bvalid && m_mod_bready && !fifo_empty;
  assign s_rsp_bdata = m_mod_bdata;

  always_comb begin
    rr_d           = rr_q;
    m_mod_valid_d  = m_mod_valid_q;
    m_mod_addr_d   = m_mod_addr_q;
    m_mod_data_d   = m_mod_data_q;
    m_mod_opcode_d = m_mod_opcode_q;
    outstanding_d  = outstanding_q;
    clear_busy_d   = clear_busy_q;
    err_orphan_d   = err_orphan_q || (m_mod_bvalid && fifo_empty);
    if (accept) begin
      m_mod_valid_d  = 1'b1;
      m_mod_addr_d   = sel_addr;
      m_mod_data_d   = sel_data;
      m_mod_opcode_d = sel_opcode;
      rr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (m_mod_ready) begin
      m_mod_valid_d = 1'b0;
    end
    unique case ({accept, rsp_pop})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase
    // No accepts while locked, so the CLEAR is the last one in flight.
    if (clear_busy_q) begin
      if (rsp_pop && outstanding_q == OW'(1)) clear_busy_d = 1'b0;
    end else if (is_clear) begin
      clear_busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q           <= '0;
      m_mod_valid_q  <= 1'b0;
      m_mod_addr_q   <= '0;
      m_mod_data_q   <= '0;
      m_mod_opcode_q <= '0;
      outstanding_q  <= '0;
      clear_busy_q   <= 1'b0;
      err_orphan_q   <= 1'b0;
    end else begin
      rr_q           <= rr_d;
      m_mod_valid_q  <= m_mod_valid_d;
      m_mod_addr_q   <= m_mod_addr_d;
      m_mod_data_q   <= m_mod_data_d;
      m_mod_opcode_q <= m_mod_opcode_d;
      outstanding_q  <= outstanding_d;
      clear_busy_q   <= clear_busy_d;
      err_orphan_q   <= err_orphan_d;
    end
  end

  rs_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (ID_W)
  ) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (accept),
    .push_id (gnt_idx),
    .pop     (rsp_pop),
    .head    (head_id),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign m_mod_valid    = m_mod_valid_q;
  assign m_mod_addr     = m_mod_addr_q;
  assign m_mod_data     = m_mod_data_q;
  assign m_mod_opcode   = m_mod_opcode_q;
  assign outstanding    = outstanding_q;
  assign clear_busy     = clear_busy_q;
  assign err_orphan_rsp = err_orphan_q;

endmodule
